// File: rtl/envelope_shaper.sv
// ADSR envelope: scales note-player samples by an 8-bit envelope stepped on the 48 Hz beat.
// Latency 1 cycle sample_in -> sample_out; no backpressure, samples are never stalled.
module envelope_shaper #(
    parameter int ATTACK_STEP   = 32,
    parameter int DECAY_STEP    = 8,
    parameter int SUSTAIN_LEVEL = 192,
    parameter int RELEASE_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_start,
    input  logic        note_done,
    input  logic        beat,
    input  logic [15:0] sample_in,
    input  logic        sample_in_ready,
    output logic [15:0] sample_out,
    output logic        sample_out_ready,
    output logic [7:0]  env_level,
    output logic [2:0]  env_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam logic [8:0]        ATK9  = 9'(ATTACK_STEP);
    localparam logic signed [9:0] DEC10 = 10'(DECAY_STEP);
    localparam logic signed [9:0] REL10 = 10'(RELEASE_STEP);
    localparam logic signed [9:0] SUS10 = 10'(SUSTAIN_LEVEL);
    localparam logic [7:0]        SUS8  = 8'(SUSTAIN_LEVEL);

    env_state_t        state_q, state_d;
    logic [7:0]        env_q, env_d;
    logic              note_done_q;
    logic              release_evt;
    logic [8:0]        attack_sum;
    logic signed [9:0] level10;
    logic signed [9:0] decay_diff;
    logic signed [9:0] release_diff;
    logic signed [24:0] prod;
    logic              unused_prod;

    // note_done is a level that stays high; only its rising edge releases
    assign release_evt  = note_done & ~note_done_q;
    assign level10      = $signed({2'b00, env_q});
    assign attack_sum   = {1'b0, env_q} + ATK9;
    assign decay_diff   = level10 - DEC10;
    assign release_diff = level10 - REL10;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (note_start) begin
            state_d = ST_ATTACK;
        end else if (release_evt && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                     state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else if (beat) begin
            case (state_q)
                ST_ATTACK: begin
                    if (attack_sum >= 9'd255) begin
                        env_d   = 8'd255;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = attack_sum[7:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_diff <= SUS10) begin
                        env_d   = SUS8;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = decay_diff[7:0];
                    end
                end
                ST_RELEASE: begin
                    if (release_diff <= 10'sd0) begin
                        env_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = release_diff[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Envelope is zero-extended so it acts as an unsigned gain of env/256
    assign prod        = $signed(sample_in) * $signed({1'b0, env_q});
    assign unused_prod = ^{prod[24], prod[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            env_q            <= 8'd0;
            note_done_q      <= 1'b0;
            sample_out       <= 16'd0;
            sample_out_ready <= 1'b0;
        end else begin
            state_q          <= state_d;
            env_q            <= env_d;
            note_done_q      <= note_done;
            sample_out_ready <= sample_in_ready;
            if (sample_in_ready) begin
                sample_out <= prod[23:8];
            end
        end
    end

    assign env_level = env_q;
    assign env_state = state_q;

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed-vector bench for envelope_shaper: ADSR stepping, sample scaling, priorities, reset.
module tb_envelope_shaper;

    logic        clk = 1'b0;
    logic        reset;
    logic        note_start;
    logic        note_done;
    logic        beat;
    logic [15:0] sample_in;
    logic        sample_in_ready;
    logic [15:0] sample_out;
    logic        sample_out_ready;
    logic [7:0]  env_level;
    logic [2:0]  env_state;

    always #5 clk = ~clk;

    envelope_shaper dut (
        .clk              (clk),
        .reset            (reset),
        .note_start       (note_start),
        .note_done        (note_done),
        .beat             (beat),
        .sample_in        (sample_in),
        .sample_in_ready  (sample_in_ready),
        .sample_out       (sample_out),
        .sample_out_ready (sample_out_ready),
        .env_level        (env_level),
        .env_state        (env_state)
    );

    typedef struct {
        logic        rst, ns, nd, bt, rdy;
        logic [15:0] sin;
        logic [7:0]  e_lvl;
        logic [2:0]  e_st;
        logic        e_rdy;
        logic        chk_out;
        logic [15:0] e_out;
    } vec_t;

    int n_vec = 0;
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] ATK_EXP [8] = '{8'd32, 8'd64, 8'd96, 8'd128, 8'd160, 8'd192, 8'd224, 8'd255};
    localparam logic [7:0] DEC_EXP [8] = '{8'd247, 8'd239, 8'd231, 8'd223, 8'd215, 8'd207, 8'd199, 8'd192};

    function automatic vec_t mk(input logic rst, input logic ns, input logic nd, input logic bt,
                                input logic rdy, input logic [15:0] sin, input logic [7:0] lvl,
                                input logic [2:0] st, input logic erdy, input logic chk,
                                input logic [15:0] eout);
        vec_t v;
        v.rst = rst; v.ns = ns; v.nd = nd; v.bt = bt; v.rdy = rdy; v.sin = sin;
        v.e_lvl = lvl; v.e_st = st; v.e_rdy = erdy; v.chk_out = chk; v.e_out = eout;
        return v;
    endfunction

    task automatic check(input string what, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", what, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset           = v.rst;
        note_start      = v.ns;
        note_done       = v.nd;
        beat            = v.bt;
        sample_in_ready = v.rdy;
        sample_in       = v.sin;
        @(posedge clk);
        #1;
        check("env_level", n_vec, {8'd0, env_level}, {8'd0, v.e_lvl});
        check("env_state", n_vec, {13'd0, env_state}, {13'd0, v.e_st});
        check("sample_out_ready", n_vec, {15'd0, sample_out_ready}, {15'd0, v.e_rdy});
        if (v.chk_out) check("sample_out", n_vec, sample_out, v.e_out);
        n_vec++;
    endtask

    task automatic attack_decay_to_sustain();
        for (int k = 0; k < 8; k++)
            apply(mk(0, 0, 0, 1, 0, 16'h0, ATK_EXP[k], (k < 7) ? 3'd1 : 3'd2, 0, 0, 16'h0));
        for (int k = 0; k < 8; k++)
            apply(mk(0, 0, 0, 1, 0, 16'h0, DEC_EXP[k], (k < 7) ? 3'd2 : 3'd3, 0, 0, 16'h0));
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; note_start = 1'b0; note_done = 1'b0; beat = 1'b0;
        sample_in = 16'h0; sample_in_ready = 1'b0;

        // Reset, then a sample at env=0 must come out as zero with a single ready pulse
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 8'd0, 3'd0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 8'd0, 3'd0, 0, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h4000, 8'd0, 3'd0, 1, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 8'd0, 3'd0, 0, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 8'd0, 3'd0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 8'd0, 3'd1, 0, 0, 16'h0000));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0, ATK_EXP[k], (k < 7) ? 3'd1 : 3'd2, 0, 0, 16'h0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0, DEC_EXP[k], (k < 7) ? 3'd2 : 3'd3, 0, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 8'd192, 3'd3, 0, 0, 16'h0000));
        // Scaling at env=192, back-to-back, then hold between pulses
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 8'd192, 3'd3, 1, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h4000, 8'd192, 3'd3, 1, 1, 16'h3000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'hC000, 8'd192, 3'd3, 1, 1, 16'hD000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h1234, 8'd192, 3'd3, 0, 1, 16'hD000));
        // Release edge with a beat in the same cycle: no step on entry
        tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 8'd192, 3'd4, 0, 0, 16'h0000));

        foreach (tbl[i]) apply(tbl[i]);

        // Release down to IDLE over 48 beats, note_done held high
        for (int k = 1; k <= 48; k++)
            apply(mk(0, 0, 1, 1, 0, 16'h0, 8'(192 - 4 * k), (k == 48) ? 3'd0 : 3'd4, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 1, 0, 16'h0, 8'd0, 3'd0, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 0, 0, 16'h0, 8'd0, 3'd0, 0, 0, 16'h0));

        // New note, release to 100, retrigger from 100
        apply(mk(0, 0, 0, 0, 0, 16'h0, 8'd0, 3'd0, 0, 0, 16'h0));
        apply(mk(0, 1, 0, 0, 0, 16'h0, 8'd0, 3'd1, 0, 0, 16'h0));
        attack_decay_to_sustain();
        apply(mk(0, 0, 1, 0, 0, 16'h0, 8'd192, 3'd4, 0, 0, 16'h0));
        for (int k = 1; k <= 23; k++)
            apply(mk(0, 0, 1, 1, 0, 16'h0, 8'(192 - 4 * k), 3'd4, 0, 0, 16'h0));
        apply(mk(0, 1, 1, 0, 0, 16'h0, 8'd100, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 1, 0, 16'h0, 8'd132, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 1, 0, 16'h0, 8'd164, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 1, 0, 16'h0, 8'd196, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 1, 0, 16'h0, 8'd228, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 1, 0, 16'h0, 8'd255, 3'd2, 0, 0, 16'h0));

        // note_start + release edge + beat together: ATTACK, level unchanged
        apply(mk(0, 0, 0, 1, 0, 16'h0, 8'd247, 3'd2, 0, 0, 16'h0));
        apply(mk(0, 1, 1, 1, 0, 16'h0, 8'd247, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 1, 0, 0, 16'h0, 8'd247, 3'd1, 0, 0, 16'h0));

        // Reset mid-ATTACK at env=96 with a nonzero sample_out pending
        apply(mk(1, 0, 0, 0, 0, 16'h0, 8'd0, 3'd0, 0, 1, 16'h0000));
        apply(mk(0, 1, 0, 0, 0, 16'h0, 8'd0, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 0, 1, 0, 16'h0, 8'd32, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 0, 1, 0, 16'h0, 8'd64, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 0, 1, 0, 16'h0, 8'd96, 3'd1, 0, 0, 16'h0));
        apply(mk(0, 0, 0, 0, 1, 16'h4000, 8'd96, 3'd1, 1, 1, 16'h1800));
        apply(mk(1, 1, 1, 1, 1, 16'h4000, 8'd0, 3'd0, 0, 1, 16'h0000));
        apply(mk(0, 0, 0, 0, 0, 16'h0, 8'd0, 3'd0, 0, 1, 16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/envelope_shaper.md
Name: envelope_shaper

Overview:
- ADSR amplitude envelope stage placed directly downstream of the note player.
- Consumes the note player's 16-bit signed sample stream and its note start/finish events.
- Scales each sample by an 8-bit envelope that advances on the 1/48 s beat, then hands the scaled sample to the codec interface.
- Removes clicks at note boundaries and gives each note attack, decay, sustain and release shaping.

Parameters:
ATTACK_STEP, 32, envelope increment per beat in ATTACK (1..255)
DECAY_STEP, 8, envelope decrement per beat in DECAY (1..255)
SUSTAIN_LEVEL, 192, envelope hold level in SUSTAIN (0..255)
RELEASE_STEP, 4, envelope decrement per beat in RELEASE (1..255)

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
note_start  input  1  one-cycle pulse when a new note is loaded (driven from load_new_note)
note_done  input  1  level, high when the note duration has expired (driven from done_with_note, which stays high)
beat  input  1  one-cycle pulse at 48 Hz; envelope step strobe
sample_in  input  16  signed sample from the note player
sample_in_ready  input  1  sample_in valid this cycle
sample_out  output  16  signed enveloped sample
sample_out_ready  output  1  one-cycle pulse, sample_out valid
env_level  output  8  current envelope value (0..255)
env_state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4

Behaviour:
- Clocking: all state updates occur on the rising edge of clk.
- Reset (synchronous, active-high): env_state=IDLE, env_level=0, sample_out=0, sample_out_ready=0, note_done edge register=0.
  - Reset mid-operation takes effect on the next edge regardless of any other input.
- Release event: release_evt = note_done & ~note_done_q, where note_done_q is a registered copy of note_done. A note_done input held high produces only one event.
- Priority each cycle:
  - reset first.
  - Then note_start: go to ATTACK, env_level unchanged (retrigger without a jump); any beat or release_evt in the same cycle is ignored.
  - Then release_evt: in ATTACK, DECAY or SUSTAIN, go to RELEASE with no step this cycle; ignored in IDLE and RELEASE.
  - Then beat stepping.
- Beat stepping (one step per beat pulse, only in the states listed):
  - ATTACK: env = min(255, env + ATTACK_STEP), computed 9 bits wide. When the result is 255, go to DECAY on the same edge.
  - DECAY: env = max(SUSTAIN_LEVEL, env - DECAY_STEP), computed as signed 10-bit to avoid underflow. When the result equals SUSTAIN_LEVEL, go to SUSTAIN on the same edge.
  - SUSTAIN: env holds; beats are ignored.
  - RELEASE: env = max(0, env - RELEASE_STEP). When the result is 0, go to IDLE on the same edge.
  - IDLE: env stays 0; beats are ignored.
- Sample path (latency 1 cycle):
  - On a cycle with sample_in_ready=1, register sample_out = bits [23:8] of the signed product sample_in × {1'b0, env_level}. env_level is its pre-edge value in that cycle.
  - The shift is arithmetic (sign preserved). env=255 therefore gives slightly under unity gain. In IDLE (env=0) the output is 0.
  - sample_out_ready is asserted the cycle after each cycle with sample_in_ready high, and is 0 otherwise.
  - sample_out holds its value between ready pulses.
  - Back-to-back sample_in_ready cycles each produce an output.
- Sample handling never stalls and does not depend on env_state; there is no backpressure.

Test Plan:
- Reset behaviour: assert reset, then sample_in=0x4000 with ready → next cycle sample_out=0x0000, sample_out_ready=1 for exactly one cycle, env_state=0.
- Attack and decay: note_start, then 8 beats → env 32,64,96,128,160,192,224,255; env_state=DECAY after the 8th beat. Then 8 more beats → 247,239,…,199,192; env_state=SUSTAIN. A further beat leaves env at 192.
- Scaling in SUSTAIN (env=192): sample_in 0x4000 → 0x3000; sample_in 0xC000 → 0xD000; 0x0000 → 0x0000; each with a one-cycle ready pulse one cycle after input.
- Release: raise note_done and hold it high → RELEASE. After 48 beats env=0 and env_state=IDLE. note_done still high causes no further state change.
- Retrigger during RELEASE at env=100: note_start → ATTACK from 100; beats give 132,164,196,228,255, then DECAY.
- Simultaneous events and reset: note_start, release_evt and beat in the same cycle → ATTACK with env unchanged. Reset asserted mid-ATTACK (env=96) → next cycle IDLE, env=0, sample_out=0.
